// File: rtl/ibuf2ddr.sv
// ibuf2ddr: reads entries 0..conf_idx_num of one PE index buffer and packs them into DDR_W-bit words on a valid/ready stream.
// Optional macro IBUF2DDR_STALL_CNT_EN adds a 16-bit saturating stall_cnt output.
module ibuf2ddr #(
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = $clog2(IDX_DEPTH),
    parameter int PE_NUM    = 32,
    parameter int DDR_W     = 64,
    parameter int IDX_W     = 8,
    parameter int PE_W      = $clog2(PE_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      done,
    input  logic [3:0]                conf_mode,
    input  logic [7:0]                conf_idx_num,
    input  logic [PE_W-1:0]           conf_pe_sel,
    output logic [PE_NUM-1:0]         idx_rd_en,
    output logic [ADDR_W-1:0]         idx_rd_addr,
    input  logic [PE_NUM*IDX_W*2-1:0] idx_rd_data,
    output logic [DDR_W-1:0]          ddr_data,
    output logic                      ddr_valid,
    output logic                      ddr_last,
    input  logic                      ddr_ready
`ifdef IBUF2DDR_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int ENT_W     = IDX_W * 2;
    localparam int IDX_BATCH = DDR_W / ENT_W;
    localparam int SLOT_W    = (IDX_BATCH > 1) ? $clog2(IDX_BATCH) : 1;
    localparam int CMP_W     = (ADDR_W > 8) ? ADDR_W : 8;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(IDX_BATCH - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DRAIN = 2'd2} state_t;

    function automatic logic [ENT_W-1:0] pick_entry(input logic [PE_NUM*ENT_W-1:0] data,
                                                    input logic [PE_W-1:0] sel,
                                                    input logic swap);
        logic [ENT_W-1:0] e;
        e = data[sel*ENT_W +: ENT_W];
        if (swap) begin
            pick_entry = {e[IDX_W-1:0], e[ENT_W-1:IDX_W]};
        end else begin
            pick_entry = e;
        end
    endfunction

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic               swap_q, swap_d;
    logic [7:0]         idx_num_q, idx_num_d;
    logic [PE_W-1:0]    pe_sel_q, pe_sel_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
    logic               land_q, land_d;
    logic [SLOT_W-1:0]  land_slot_q, land_slot_d;
    logic               land_cmpl_q, land_cmpl_d;
    logic               land_last_q, land_last_d;
    logic [DDR_W-1:0]   pack_q, pack_d;
    logic [DDR_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;

    logic               start_acc_s;
    logic               rd_is_last_s;
    logic               rd_cmpl_s;
    logic               out_acc_s;
    logic               out_free_s;
    logic               rd_go_s;
    logic [ENT_W-1:0]   entry_s;
    logic [DDR_W-1:0]   word_s;
    logic               unused_mode_s;

    assign unused_mode_s = ^{conf_mode[3], conf_mode[0]};

    // A word-completing read must not land while the output register is still occupied.
    assign start_acc_s  = start && done_q;
    assign rd_is_last_s = (CMP_W'(rd_addr_q) == CMP_W'(idx_num_q));
    assign rd_cmpl_s    = rd_is_last_s || (rd_slot_q == LAST_SLOT);
    assign out_acc_s    = out_valid_q && ddr_ready;
    assign out_free_s   = (!out_valid_q || ddr_ready) && !(land_q && land_cmpl_q);

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_READ;
                else       state_d = ST_IDLE;
            end
            ST_READ: begin
                if (rd_go_s && rd_is_last_s) state_d = ST_DRAIN;
                else                         state_d = ST_READ;
            end
            ST_DRAIN: begin
                if (out_acc_s && out_last_q) state_d = ST_IDLE;
                else                         state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_IDLE);
    end

    // FSM outputs: read issue and one-hot read enable
    always_comb begin
        rd_go_s   = 1'b0;
        idx_rd_en = {PE_NUM{1'b0}};
        if (state_q == ST_READ) begin
            rd_go_s = !rd_cmpl_s || out_free_s;
        end else begin
            rd_go_s = 1'b0;
        end
        if (rd_go_s) begin
            idx_rd_en[pe_sel_q] = 1'b1;
        end else begin
            idx_rd_en = {PE_NUM{1'b0}};
        end
    end

    // Datapath: configuration capture, read counters, packing and output register
    always_comb begin
        swap_d      = swap_q;
        idx_num_d   = idx_num_q;
        pe_sel_d    = pe_sel_q;
        rd_addr_d   = rd_addr_q;
        rd_slot_d   = rd_slot_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        land_d      = rd_go_s;
        land_slot_d = rd_slot_q;
        land_cmpl_d = rd_cmpl_s;
        land_last_d = rd_is_last_s;
        entry_s     = pick_entry(idx_rd_data, pe_sel_q, swap_q);
        word_s      = pack_q;

        if (start_acc_s) begin
            swap_d    = (conf_mode[2:1] == 2'b01);
            idx_num_d = conf_idx_num;
            pe_sel_d  = conf_pe_sel;
            rd_addr_d = {ADDR_W{1'b0}};
            rd_slot_d = {SLOT_W{1'b0}};
            pack_d    = {DDR_W{1'b0}};
        end else if (rd_go_s) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (rd_slot_q == LAST_SLOT) rd_slot_d = {SLOT_W{1'b0}};
            else                        rd_slot_d = rd_slot_q + SLOT_W'(1);
        end else begin
            rd_addr_d = rd_addr_q;
        end

        if (out_acc_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (land_q) begin
            word_s[land_slot_q*ENT_W +: ENT_W] = entry_s;
            if (land_cmpl_q) begin
                out_data_d  = word_s;
                out_valid_d = 1'b1;
                out_last_d  = land_last_q;
                pack_d      = {DDR_W{1'b0}};
            end else begin
                pack_d = word_s;
            end
        end else begin
            word_s = pack_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b1;
            swap_q      <= 1'b0;
            idx_num_q   <= 8'd0;
            pe_sel_q    <= {PE_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_slot_q   <= {SLOT_W{1'b0}};
            land_q      <= 1'b0;
            land_slot_q <= {SLOT_W{1'b0}};
            land_cmpl_q <= 1'b0;
            land_last_q <= 1'b0;
            pack_q      <= {DDR_W{1'b0}};
            out_data_q  <= {DDR_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            swap_q      <= swap_d;
            idx_num_q   <= idx_num_d;
            pe_sel_q    <= pe_sel_d;
            rd_addr_q   <= rd_addr_d;
            rd_slot_q   <= rd_slot_d;
            land_q      <= land_d;
            land_slot_q <= land_slot_d;
            land_cmpl_q <= land_cmpl_d;
            land_last_q <= land_last_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign done        = done_q;
    assign idx_rd_addr = rd_addr_q;
    assign ddr_data    = out_data_q;
    assign ddr_valid   = out_valid_q;
    assign ddr_last    = out_last_q;

`ifdef IBUF2DDR_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of backpressured cycles within a transfer
    always_comb begin
        stall_d = stall_q;
        if (start_acc_s) begin
            stall_d = 16'd0;
        end else if ((state_q != ST_IDLE) && out_valid_q && !ddr_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ibuf2ddr.sv
// Scoreboard bench for ibuf2ddr (DDR_W=64, IDX_W=8, 4 entries per word); expected words come from a reference model of the packing rules.
module tb_ibuf2ddr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         done;
    logic [3:0]   conf_mode = 4'd0;
    logic [7:0]   conf_idx_num = 8'd0;
    logic [4:0]   conf_pe_sel = 5'd0;
    logic [31:0]  idx_rd_en;
    logic [7:0]   idx_rd_addr;
    logic [511:0] idx_rd_data;
    logic [63:0]  ddr_data;
    logic         ddr_valid;
    logic         ddr_last;
    logic         ddr_ready = 1'b1;
`ifdef IBUF2DDR_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    ibuf2ddr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .done         (done),
        .conf_mode    (conf_mode),
        .conf_idx_num (conf_idx_num),
        .conf_pe_sel  (conf_pe_sel),
        .idx_rd_en    (idx_rd_en),
        .idx_rd_addr  (idx_rd_addr),
        .idx_rd_data  (idx_rd_data),
        .ddr_data     (ddr_data),
        .ddr_valid    (ddr_valid),
        .ddr_last     (ddr_last),
        .ddr_ready    (ddr_ready)
`ifdef IBUF2DDR_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:31][0:255];
    logic [63:0] exp_data [$];
    bit          exp_last [$];
    int          acc_cyc [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          mon_sel = 0;
    int          mon_addr = 0;
    int          mon_num = 0;
    int          rd_count = 0;

    function automatic void check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Reference model: word w holds entries 4w..4w+3 (clipped at num), entry j of the word in bits 16j+15:16j.
    function automatic void push_expected(input int sel, input logic [3:0] mode, input int num);
        int nwords;
        logic [63:0] w;
        logic [15:0] e;
        nwords = num / 4 + 1;
        for (int wi = 0; wi < nwords; wi++) begin
            w = 64'd0;
            for (int j = 0; j < 4; j++) begin
                if (4 * wi + j <= num) begin
                    e = mem[sel][4 * wi + j];
                    if (mode[2:1] == 2'b01) e = {e[7:0], e[15:8]};
                    w = w | ({48'd0, e} << (16 * j));
                end
            end
            exp_data.push_back(w);
            exp_last.push_back(wi == nwords - 1);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Index buffer model: one-cycle read latency, unselected PEs return noise
    always @(posedge clk) begin
        for (int p = 0; p < 32; p++) begin
            if (idx_rd_en[p]) idx_rd_data[p*16 +: 16] <= mem[p][idx_rd_addr];
            else              idx_rd_data[p*16 +: 16] <= 16'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ddr_ready = 1'b1;
            1:       ddr_ready = 1'b0;
            default: ddr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: read port, output hold stability, scoreboard pops, done timing
    bit          hold_v = 1'b0;
    logic [63:0] hold_d;
    bit          hold_l;
    bit          done_chk = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v   = 1'b0;
            done_chk = 1'b0;
        end else begin
            if (idx_rd_en != 32'd0) begin
                check(idx_rd_en == (32'd1 << mon_sel), "rd_en_onehot", {32'd0, idx_rd_en}, {32'd0, 32'd1 << mon_sel});
                check((idx_rd_addr == 8'(mon_addr)) && (mon_addr <= mon_num), "rd_addr", {56'd0, idx_rd_addr}, 64'(mon_addr));
                mon_addr++;
                rd_count++;
            end
            if (done_chk) begin
                check(done && (idx_rd_en == 32'd0), "done_after_last", {63'd0, done}, 64'd1);
                done_chk = 1'b0;
            end
            if (hold_v) begin
                check(ddr_valid && (ddr_data == hold_d) && (ddr_last == hold_l), "hold_stable", ddr_data, hold_d);
            end
            if (ddr_valid && ddr_ready) begin
                hold_v = 1'b0;
                acc_cyc.push_back(cyc);
                if (exp_data.size() == 0) begin
                    check(1'b0, "unexpected_word", ddr_data, 64'd0);
                end else begin
                    check(ddr_data == exp_data[0], "word_data", ddr_data, exp_data[0]);
                    check(ddr_last == exp_last[0], "word_last", {63'd0, ddr_last}, {63'd0, exp_last[0]});
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
                if (ddr_last) begin
                    check(!done, "done_low_at_last", {63'd0, done}, 64'd0);
                    done_chk = 1'b1;
                end
            end else if (ddr_valid) begin
                hold_v = 1'b1;
                hold_d = ddr_data;
                hold_l = ddr_last;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic check_reset(input string tag);
        check(done == 1'b1, {tag, "_done"}, {63'd0, done}, 64'd1);
        check(idx_rd_en == 32'd0, {tag, "_rd_en"}, {32'd0, idx_rd_en}, 64'd0);
        check(idx_rd_addr == 8'd0, {tag, "_rd_addr"}, {56'd0, idx_rd_addr}, 64'd0);
        check(!ddr_valid && !ddr_last, {tag, "_valid_last"}, {62'd0, ddr_valid, ddr_last}, 64'd0);
        check(ddr_data == 64'd0, {tag, "_data"}, ddr_data, 64'd0);
    endtask

    task automatic start_xfer(input int sel, input logic [3:0] mode, input int num);
        push_expected(sel, mode, num);
        mon_sel  = sel;
        mon_addr = 0;
        mon_num  = num;
        rd_count = 0;
        acc_cyc.delete();
        @(posedge clk); #1;
        conf_pe_sel  = 5'(sel);
        conf_mode    = mode;
        conf_idx_num = 8'(num);
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        conf_pe_sel  = 5'($urandom);
        conf_mode    = 4'($urandom);
        conf_idx_num = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        check(done == 1'b0, {tag, "_busy"}, {63'd0, done}, 64'd0);
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(done == 1'b1, {tag, "_done_timeout"}, {63'd0, done}, 64'd1);
        check(exp_data.size() == 0, {tag, "_all_words"}, 64'(exp_data.size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ddr_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(ddr_valid == 1'b1, {tag, "_valid_timeout"}, {63'd0, ddr_valid}, 64'd1);
    endtask

    int gap;
    int snap;

    initial begin
        for (int p = 0; p < 32; p++)
            for (int a = 0; a < 256; a++)
                mem[p][a] = (p == 3) ? 16'(16'h0100 + a) : 16'($urandom);

        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 1: two full words, full throughput
        ready_mode = 0;
        start_xfer(3, 4'd0, 7);
        wait_done("t1");
        gap = (acc_cyc.size() == 2) ? (acc_cyc[1] - acc_cyc[0]) : -1;
        check(gap == 4, "t1_word_gap", 64'(gap), 64'd4);

        // 2: partial final word zero-filled
        start_xfer(3, 4'd0, 5);
        wait_done("t2");

        // 3: half swap
        start_xfer(3, 4'b0010, 3);
        wait_done("t3");

        // 4: backpressure for 10 cycles after the first valid
        ready_mode = 1;
        start_xfer(3, 4'd0, 15);
        wait_valid("t4");
        repeat (5) @(posedge clk);
        snap = rd_count;
        repeat (5) @(posedge clk);
        check(rd_count <= 8, "t4_reads_bounded", 64'(rd_count), 64'd8);
        check(rd_count == snap, "t4_reads_stopped", 64'(rd_count), 64'(snap));
        ready_mode = 0;
        wait_done("t4");
`ifdef IBUF2DDR_STALL_CNT_EN
        check(stall_cnt == 16'd10, "t4_stall_cnt", {48'd0, stall_cnt}, 64'd10);
`endif

        // 5: reset while the second word is pending, then a one-entry transfer
        ready_mode = 1;
        start_xfer(3, 4'd0, 7);
        wait_valid("t5");
        @(posedge clk);
        ready_mode = 0;
        @(posedge clk);
        ready_mode = 1;
        repeat (8) @(negedge clk);
        check(ddr_valid && !ddr_ready, "t5_pending", {62'd0, ddr_valid, ddr_ready}, 64'd2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset("t5_reset");
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(posedge clk); #2;
        rst_n = 1'b1;
        ready_mode = 0;
        start_xfer(3, 4'd0, 0);
        wait_done("t5b");

        // 6: start while busy is ignored
        start_xfer(3, 4'd0, 7);
        repeat (3) @(posedge clk); #1;
        conf_pe_sel  = 5'd5;
        conf_idx_num = 8'd2;
        conf_mode    = 4'b0010;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        wait_done("t6");

        // Randomised transfers with random backpressure, including a full 256-entry buffer
        ready_mode = 2;
        for (int t = 0; t < 12; t++) begin
            start_xfer($urandom_range(0, 31), 4'($urandom), (t == 0) ? 255 : $urandom_range(0, 40));
            wait_done("rand");
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
